psum_accum: RTL and testbench
=============================

# psum_accum

Partial-sum accumulation stage directly downstream of the output FIFO. It drains column-wide partial-sum words from the FIFO and performs a read-modify-write against the single-port psum SRAM: saturating add onto the stored value, then optional ReLU. It also handles first-pass overwrite and final-pass ReLU. It replaces host-sequenced per-word read/add/write instruction traffic with one start command per pass.

## Interface

- col, 8, number of lanes (mac columns) per word
- psum_bw, 16, signed two's-complement width per lane
- addr_w, 11, psum SRAM address width

- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle command pulse; sampled only in IDLE
- base_addr  in  addr_w  first SRAM address of the pass (sampled with start)
- len  in  addr_w+1  words in pass, 0..2^addr_w (sampled with start)
- first  in  1  1: overwrite (no SRAM read); 0: accumulate
- relu_en  in  1  apply ReLU to the value written (sampled with start)
- in_valid  in  1  FIFO has a word (ofifo_valid)
- in_ready  out  1  FIFO read strobe; transfer = in_valid & in_ready
- in_data  in  col*psum_bw  FIFO word; lane k at [k*psum_bw +: psum_bw]
- sram_cen  out  1  active-low chip enable
- sram_wen  out  1  active-low write enable
- sram_addr  out  addr_w  SRAM address
- sram_d  out  col*psum_bw  write data
- sram_q  in  col*psum_bw  read data; valid the cycle after a read
- busy  out  1  high in any state but IDLE
- done  out  1  one-cycle pulse at end of pass

## Operation

- States: IDLE, OVR (first pass), RD, WR (accumulate pass), FIN.
- IDLE + start:
  - Latch base_addr into addr counter, len into remaining counter, and relu_en.
  - Go to FIN if len==0, else OVR if first=1, else RD.
  - start outside IDLE is ignored.
- OVR:
  - in_ready=1.
  - On transfer: sram_cen=0, sram_wen=0, sram_addr=addr, sram_d=f(in_data); addr++, remaining--.
  - When remaining reaches 0 → FIN.
- RD:
  - in_ready=1.
  - On transfer: sram_cen=0, sram_wen=1, sram_addr=addr; latch in_data; → WR.
  - No transfer: SRAM idle, stay in RD.
- WR:
  - in_ready=0.
  - sram_cen=0, sram_wen=0, sram_addr=addr, sram_d=f(sat_add(sram_q, latched)).
  - addr++, remaining--.
  - → FIN if remaining reaches 0, else → RD.
- FIN: done=1 for one cycle → IDLE.
- Lane arithmetic (per lane, signed psum_bw):
  - sat_add clamps to [-2^(psum_bw-1), 2^(psum_bw-1)-1], i.e. [-32768, 32767] at default width.
  - f(x) = (relu_en and x<0) ? 0 : x.
- addr counter wraps modulo 2^addr_w.
- sram_cen=1, sram_wen=1 whenever no access is issued; sram_d is don't-care then.

## Timing

- Reset values: state=IDLE, in_ready=0, sram_cen=1, sram_wen=1, sram_addr=0, sram_d=0, busy=0, done=0. Internal counters and the latched word clear to 0.
- Reset mid-pass aborts immediately: no further SRAM access, no done pulse.
- in_ready, sram_cen, sram_wen, sram_addr, sram_d are combinational from state, registers and in_valid. The access is issued in the same cycle as the transfer.
- busy is registered.
- Throughput:
  - OVR: 1 word/cycle.
  - Accumulate: 1 word per 2 cycles (single-port SRAM; read and write never in the same cycle).
- Latency:
  - start → first possible transfer: 1 cycle.
  - Last write → done: 1 cycle.
  - done → start accepted: 1 cycle (IDLE).
- in_valid low stalls only in OVR/RD. WR always completes.
- in_data/in_valid are ignored in IDLE, WR and FIN.

## Structure

- Package psum_accum_pkg holds:
  - state enum (IDLE, OVR, RD, WR, FIN);
  - lane saturation min/max constants derived from psum_bw.
- Sub-module psum_lane_alu: one lane's sat_add + ReLU, combinational, instantiated col times via generate.

## Test plan

- Overwrite: start first=1, relu_en=0, base=5, len=3, FIFO always valid with lanes 1,2,3 → writes at addr 5,6,7 on three consecutive cycles; done one cycle after addr 7.
- Accumulate: SRAM[0] lane0=100, start first=0, len=1, in lane0=-30 → read addr 0, next cycle write lane0=70; 2-cycle cadence; done pulse.
- Saturation and ReLU:
  - stored 32000 + in 1000 → 32767.
  - stored -32000 + in -1000 → -32768; with relu_en=1 → 0.
- Stall and wrap:
  - in_valid toggled 1,0,0,1 in RD → exactly one SRAM access per accepted word, none while stalled.
  - base=2047, len=2 → writes to 2047 then 0.
- Edge commands:
  - len=0 → done one cycle after start, sram_cen never low.
  - start while busy is ignored.
  - reset asserted in WR → outputs return to reset values asynchronously, no done.

Source files
------------

// File: rtl/psum_accum_pkg.sv
// Shared types and constants for the partial-sum accumulation stage.
// Lane width, lane count and SRAM address width live here so that the
// lane ALU and the sequencer agree on saturation bounds and counter sizes.
package psum_accum_pkg;

   localparam int COL     = 8;
   localparam int PSUM_BW = 16;
   localparam int ADDR_W  = 11;
   localparam int WORD_W  = COL * PSUM_BW;

   // Signed lane bounds expressed as raw two's-complement bit patterns.
   localparam logic [PSUM_BW-1:0] LANE_MAX = {1'b0, {(PSUM_BW-1){1'b1}}};
   localparam logic [PSUM_BW-1:0] LANE_MIN = {1'b1, {(PSUM_BW-1){1'b0}}};

   // Counter step constants sized to their counters.
   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_OVR  = 3'd1,
      ST_RD   = 3'd2,
      ST_WR   = 3'd3,
      ST_FIN  = 3'd4
   } state_t;

   // Clamp a one-bit-wider signed sum back into the lane range.
   // Overflow shows up as the two top bits disagreeing; the top bit then
   // tells which way it went.
   function automatic logic [PSUM_BW-1:0] lane_sat(input logic [PSUM_BW:0] sum);
      logic [PSUM_BW-1:0] res;
      if (sum[PSUM_BW] != sum[PSUM_BW-1]) begin
         if (sum[PSUM_BW]) begin
            res = LANE_MIN;
         end else begin
            res = LANE_MAX;
         end
      end else begin
         res = sum[PSUM_BW-1:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/psum_lane_alu.sv
// One lane of the psum datapath: optional saturating add of the incoming
// word onto the stored value, followed by optional ReLU. Purely combinational.
module psum_lane_alu
   import psum_accum_pkg::*;
(
   input  logic [PSUM_BW-1:0] i_stored,
   input  logic [PSUM_BW-1:0] i_word,
   input  logic               i_add_en,
   input  logic               i_relu_en,
   output logic [PSUM_BW-1:0] o_res
);

   logic [PSUM_BW:0]   w_sum;
   logic [PSUM_BW-1:0] w_pre;

   // Sign-extended add, saturate, then clamp negatives to zero when ReLU is on.
   always_comb begin
      w_sum = {i_stored[PSUM_BW-1], i_stored} + {i_word[PSUM_BW-1], i_word};
      if (i_add_en) begin
         w_pre = lane_sat(w_sum);
      end else begin
         w_pre = i_word;
      end
      if (i_relu_en && w_pre[PSUM_BW-1]) begin
         o_res = {PSUM_BW{1'b0}};
      end else begin
         o_res = w_pre;
      end
   end

endmodule

// File: rtl/psum_accum.sv
// Partial-sum accumulation sequencer. Drains FIFO words and writes them to
// the single-port psum SRAM, either overwriting (first pass) or doing a
// read-modify-write with saturating add. ReLU is applied to what is written.
// SRAM controls are combinational so the access lands in the transfer cycle.
module psum_accum
   import psum_accum_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_base_addr,
   input  logic [ADDR_W:0]   i_len,
   input  logic              i_first,
   input  logic              i_relu_en,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [WORD_W-1:0] i_in_data,
   output logic              o_sram_cen,
   output logic              o_sram_wen,
   output logic [ADDR_W-1:0] o_sram_addr,
   output logic [WORD_W-1:0] o_sram_d,
   input  logic [WORD_W-1:0] i_sram_q,
   output logic              o_busy,
   output logic              o_done
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_addr;
   logic [ADDR_W:0]     r_rem;
   logic                r_relu;
   logic [WORD_W-1:0]   r_data;
   logic                r_busy;

   logic                w_last;
   logic                w_add_en;
   logic [WORD_W-1:0]   w_alu_word;
   logic [WORD_W-1:0]   w_alu_res;

   assign w_last   = (r_rem == REM_ONE);
   assign w_add_en = (r_state == ST_WR);
   assign o_busy   = r_busy;

   // Lane operand: the latched FIFO word during the write-back, live FIFO data otherwise.
   always_comb begin
      if (r_state == ST_WR) begin
         w_alu_word = r_data;
      end else begin
         w_alu_word = i_in_data;
      end
   end

   genvar g;
   generate
      for (g = 0; g < COL; g++) begin : g_lane
         psum_lane_alu u_lane (
            .i_stored  (i_sram_q[g*PSUM_BW +: PSUM_BW]),
            .i_word    (w_alu_word[g*PSUM_BW +: PSUM_BW]),
            .i_add_en  (w_add_en),
            .i_relu_en (r_relu),
            .o_res     (w_alu_res[g*PSUM_BW +: PSUM_BW])
         );
      end
   endgenerate

   // Next-state decode and SRAM/FIFO handshake, all idle by default.
   always_comb begin
      w_state_nxt = r_state;
      o_in_ready  = 1'b0;
      o_sram_cen  = 1'b1;
      o_sram_wen  = 1'b1;
      o_sram_addr = r_addr;
      o_sram_d    = {WORD_W{1'b0}};
      o_done      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               if (i_len == {(ADDR_W+1){1'b0}}) begin
                  w_state_nxt = ST_FIN;
               end else if (i_first) begin
                  w_state_nxt = ST_OVR;
               end else begin
                  w_state_nxt = ST_RD;
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_OVR: begin
            o_in_ready = 1'b1;
            if (i_in_valid) begin
               o_sram_cen = 1'b0;
               o_sram_wen = 1'b0;
               o_sram_d   = w_alu_res;
               if (w_last) begin
                  w_state_nxt = ST_FIN;
               end else begin
                  w_state_nxt = ST_OVR;
               end
            end else begin
               w_state_nxt = ST_OVR;
            end
         end
         ST_RD: begin
            o_in_ready = 1'b1;
            if (i_in_valid) begin
               o_sram_cen  = 1'b0;
               w_state_nxt = ST_WR;
            end else begin
               w_state_nxt = ST_RD;
            end
         end
         ST_WR: begin
            o_sram_cen = 1'b0;
            o_sram_wen = 1'b0;
            o_sram_d   = w_alu_res;
            if (w_last) begin
               w_state_nxt = ST_FIN;
            end else begin
               w_state_nxt = ST_RD;
            end
         end
         ST_FIN: begin
            o_done      = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register and registered busy flag (busy mirrors the next state).
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt != ST_IDLE);
      end
   end

   // Pass bookkeeping: address/remaining counters, ReLU mode and the word held across RD->WR.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_addr <= {ADDR_W{1'b0}};
         r_rem  <= {(ADDR_W+1){1'b0}};
         r_relu <= 1'b0;
         r_data <= {WORD_W{1'b0}};
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_addr <= i_base_addr;
                  r_rem  <= i_len;
                  r_relu <= i_relu_en;
               end
            end
            ST_OVR: begin
               if (i_in_valid) begin
                  r_addr <= r_addr + ADDR_ONE;
                  r_rem  <= r_rem - REM_ONE;
               end
            end
            ST_RD: begin
               if (i_in_valid) begin
                  r_data <= i_in_data;
               end
            end
            ST_WR: begin
               r_addr <= r_addr + ADDR_ONE;
               r_rem  <= r_rem - REM_ONE;
            end
            default: begin
               r_addr <= r_addr;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_psum_accum.sv
// Self-checking bench for psum_accum: a behavioural SRAM, a FIFO driver with
// optional stalls, and a reference model that computes each pass's expected
// SRAM access sequence with plain integer arithmetic.
module tb_psum_accum;

   typedef struct {
      logic         wen;
      logic [10:0]  addr;
      logic [127:0] d;
      int           cyc;
   } acc_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [10:0]  base;
   logic [11:0]  len;
   logic         first;
   logic         relu;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         cen;
   logic         wen;
   logic [10:0]  saddr;
   logic [127:0] sd;
   logic [127:0] sq;
   logic         busy;
   logic         done;

   logic         pl_en = 1'b0;
   logic [10:0]  pl_addr;
   logic [127:0] pl_data;
   logic [127:0] mem [0:2047];
   logic [127:0] ref_mem [0:2047];

   int           n_cmp = 0;
   int           n_err = 0;
   logic [127:0] stim_q[$];
   acc_t         acc_q[$];
   acc_t         exp_q[$];
   int           done_cyc;
   int           done_cnt;
   bit           busy_ok;

   always #5 clk = ~clk;

   psum_accum dut (
      .i_clk       (clk),
      .i_reset     (rst),
      .i_start     (start),
      .i_base_addr (base),
      .i_len       (len),
      .i_first     (first),
      .i_relu_en   (relu),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .i_in_data   (in_data),
      .o_sram_cen  (cen),
      .o_sram_wen  (wen),
      .o_sram_addr (saddr),
      .o_sram_d    (sd),
      .i_sram_q    (sq),
      .o_busy      (busy),
      .o_done      (done)
   );

   // Behavioural single-port SRAM with a backdoor preload port.
   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (!cen) begin
         if (wen) sq <= mem[saddr];
         else     mem[saddr] <= sd;
      end
   end

   // Per-lane reference arithmetic: optional saturating add, then optional ReLU.
   function automatic logic [127:0] lanes_op(input logic [127:0] s, input logic [127:0] w,
                                             input bit add, input bit r);
      logic [127:0] o;
      for (int k = 0; k < 8; k++) begin
         logic [15:0] sv;
         logic [15:0] wv;
         int a;
         int b;
         int x;
         sv = s[k*16 +: 16];
         wv = w[k*16 +: 16];
         a = $signed(sv);
         b = $signed(wv);
         x = add ? a + b : b;
         if (x > 32767) x = 32767;
         if (x < -32768) x = -32768;
         if (r && x < 0) x = 0;
         o[k*16 +: 16] = x[15:0];
      end
      return o;
   endfunction

   function automatic logic [127:0] rand_word();
      logic [127:0] w;
      for (int k = 0; k < 8; k++) begin
         logic [15:0] v;
         case ($urandom_range(0, 2))
            0: v = 16'h7F00 + 16'($urandom_range(0, 255));
            1: v = 16'h8000 + 16'($urandom_range(0, 255));
            default: v = 16'($urandom);
         endcase
         w[k*16 +: 16] = v;
      end
      return w;
   endfunction

   task automatic preload(input logic [10:0] a, input logic [127:0] v);
      @(negedge clk);
      pl_en = 1'b1; pl_addr = a; pl_data = v;
      ref_mem[a] = v;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   // Reference model: expected access sequence of one pass; updates ref_mem.
   task automatic ref_pass(input logic [10:0] b, input int l, input bit f, input bit r);
      exp_q.delete();
      for (int i = 0; i < l; i++) begin
         logic [10:0]  a;
         logic [127:0] v;
         a = b + 11'(i);
         if (!f) exp_q.push_back('{1'b1, a, 128'd0, 0});
         v = lanes_op(ref_mem[a], stim_q[i], !f, r);
         exp_q.push_back('{1'b0, a, v, 0});
         ref_mem[a] = v;
      end
   endtask

   // Drive one pass from start to done and record every SRAM access seen.
   task automatic run_pass(input logic [10:0] b, input logic [11:0] l, input logic f,
                           input logic r, input int mode, input int inj_cyc);
      int idx = 0;
      int limit;
      bit fin = 0;
      logic v;
      acc_q.delete();
      done_cyc = -1; done_cnt = 0; busy_ok = 1;
      limit = 4 * int'(l) + 20;
      @(negedge clk);
      start = 1'b1; base = b; len = l; first = f; relu = r; in_valid = 1'b0;
      for (int c = 1; c <= limit && !fin; c++) begin
         @(negedge clk);
         start = (c == inj_cyc);
         if (c == inj_cyc) begin
            base = 11'd100; len = 12'd1; first = ~f; relu = ~r;
         end
         case (mode)
            0: v = 1'b1;
            1: v = 1'($urandom_range(0, 1));
            default: v = (c % 4 == 1) || (c % 4 == 0);
         endcase
         if (idx >= stim_q.size()) v = 1'b0;
         in_valid = v;
         in_data  = v ? stim_q[idx] : {$urandom, $urandom, $urandom, $urandom};
         #1;
         if (!cen) begin
            acc_q.push_back('{wen, saddr, sd, c});
            if (wen) begin
               n_cmp++;
               if (!in_valid) begin
                  n_err++;
                  $display("FAIL read_without_valid: cycle %0d read issued with in_valid=0, required none", c);
               end
            end
         end
         if (in_valid && in_ready) idx++;
         if (done) begin done_cnt++; done_cyc = c; end
         if (done_cyc >= 0 && c == done_cyc + 1) begin
            fin = 1;
            if (busy) busy_ok = 0;
         end else if (!busy) begin
            busy_ok = 0;
         end
      end
      start = 1'b0; in_valid = 1'b0;
      if (!fin) begin
         n_cmp++; n_err++;
         $display("FAIL pass_timeout: no done within %0d cycles, required done", limit);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; in_valid = 1'b1; in_data = '0;
      base = '0; len = '0; first = 1'b0; relu = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk); #1;
      n_cmp++;
      if ({in_ready, cen, wen, busy, done} !== 5'b01100) begin
         n_err++;
         $display("FAIL reset_ctrl: got ready/cen/wen/busy/done=%b, required 01100",
                  {in_ready, cen, wen, busy, done});
      end
      n_cmp++;
      if (saddr !== 11'd0 || sd !== 128'd0) begin
         n_err++;
         $display("FAIL reset_data: got addr=%0d d=%h, required 0/0", saddr, sd);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_overwrite();
      stim_q.delete();
      for (int i = 0; i < 3; i++) stim_q.push_back({8{16'(i + 1)}});
      ref_pass(11'd5, 3, 1, 0);
      run_pass(11'd5, 12'd3, 1'b1, 1'b0, 0, 0);
      n_cmp++;
      if (acc_q.size() !== 3) begin
         n_err++; $display("FAIL ovr_count: got %0d accesses, required 3", acc_q.size());
      end
      for (int i = 0; i < 3 && i < acc_q.size(); i++) begin
         n_cmp++;
         if (acc_q[i].wen !== 1'b0 || acc_q[i].addr !== 11'(5 + i) || acc_q[i].d !== exp_q[i].d
             || acc_q[i].cyc !== i + 1) begin
            n_err++;
            $display("FAIL ovr_write%0d: got wen=%b addr=%0d cyc=%0d d=%h, required 0/%0d/%0d/%h",
                     i, acc_q[i].wen, acc_q[i].addr, acc_q[i].cyc, acc_q[i].d, 5 + i, i + 1, exp_q[i].d);
         end
      end
      n_cmp++;
      if (done_cyc !== 4 || done_cnt !== 1 || !busy_ok) begin
         n_err++;
         $display("FAIL ovr_done: got done_cyc=%0d cnt=%0d busy_ok=%0d, required 4/1/1",
                  done_cyc, done_cnt, busy_ok);
      end
   endtask

   task automatic test_accumulate();
      preload(11'd0, {112'd0, 16'd100});
      stim_q.delete();
      stim_q.push_back({112'd0, 16'hFFE2});
      run_pass(11'd0, 12'd1, 1'b0, 1'b0, 0, 0);
      ref_mem[0] = {112'd0, 16'd70};
      n_cmp++;
      if (acc_q.size() !== 2 || acc_q[0].wen !== 1'b1 || acc_q[0].addr !== 11'd0 || acc_q[0].cyc !== 1) begin
         n_err++; $display("FAIL acc_read: got %0d accesses, first wen=%b addr=%0d, required read of 0 at cycle 1",
                           acc_q.size(), acc_q[0].wen, acc_q[0].addr);
      end else begin
         n_cmp++;
         if (acc_q[1].wen !== 1'b0 || acc_q[1].cyc !== 2 || acc_q[1].d !== {112'd0, 16'd70}) begin
            n_err++; $display("FAIL acc_write: got wen=%b cyc=%0d d=%h, required 0/2/lane0=70",
                              acc_q[1].wen, acc_q[1].cyc, acc_q[1].d);
         end
      end
      n_cmp++;
      if (done_cyc !== 3 || done_cnt !== 1) begin
         n_err++; $display("FAIL acc_done: got done_cyc=%0d cnt=%0d, required 3/1", done_cyc, done_cnt);
      end
   endtask

   task automatic test_saturation_relu();
      preload(11'd10, {112'd0, 16'd32000});
      preload(11'd11, {112'd0, 16'h8300});
      preload(11'd12, {112'd0, 16'h8300});
      stim_q.delete();
      stim_q.push_back({112'd0, 16'd1000});
      stim_q.push_back({112'd0, 16'hFC18});
      run_pass(11'd10, 12'd2, 1'b0, 1'b0, 0, 0);
      n_cmp++;
      if (acc_q.size() !== 4 || acc_q[1].d[15:0] !== 16'h7FFF || acc_q[3].d[15:0] !== 16'h8000) begin
         n_err++; $display("FAIL sat_clamp: got %0d accesses lane0 %h/%h, required 4 accesses 7fff/8000",
                           acc_q.size(), acc_q[1].d[15:0], acc_q[3].d[15:0]);
      end
      ref_mem[10] = {112'd0, 16'h7FFF};
      ref_mem[11] = {112'd0, 16'h8000};
      stim_q.delete();
      stim_q.push_back({112'd0, 16'hFC18});
      run_pass(11'd12, 12'd1, 1'b0, 1'b1, 0, 0);
      ref_mem[12] = 128'd0;
      n_cmp++;
      if (acc_q.size() !== 2 || acc_q[1].d !== 128'd0) begin
         n_err++; $display("FAIL sat_relu: got %0d accesses d=%h, required 2 accesses d=0",
                           acc_q.size(), acc_q[1].d);
      end
   endtask

   task automatic test_stall();
      stim_q.delete();
      for (int i = 0; i < 3; i++) stim_q.push_back(rand_word());
      ref_pass(11'd400, 3, 1, 0);
      run_pass(11'd400, 12'd3, 1'b1, 1'b0, 0, 0);
      stim_q.delete();
      for (int i = 0; i < 3; i++) stim_q.push_back(rand_word());
      ref_pass(11'd400, 3, 0, 0);
      run_pass(11'd400, 12'd3, 1'b0, 1'b0, 2, 0);
      n_cmp++;
      if (acc_q.size() !== exp_q.size()) begin
         n_err++; $display("FAIL stall_count: got %0d accesses, required %0d", acc_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
         n_cmp++;
         if (acc_q[i].wen !== exp_q[i].wen || acc_q[i].addr !== exp_q[i].addr ||
             (!exp_q[i].wen && (acc_q[i].d !== exp_q[i].d || acc_q[i].cyc !== acc_q[i-1].cyc + 1))) begin
            n_err++; $display("FAIL stall_acc%0d: got wen=%b addr=%0d d=%h, required wen=%b addr=%0d d=%h",
                              i, acc_q[i].wen, acc_q[i].addr, acc_q[i].d, exp_q[i].wen, exp_q[i].addr, exp_q[i].d);
         end
      end
   endtask

   task automatic test_wrap();
      stim_q.delete();
      for (int i = 0; i < 2; i++) stim_q.push_back(rand_word());
      ref_pass(11'd2047, 2, 1, 1);
      run_pass(11'd2047, 12'd2, 1'b1, 1'b1, 0, 0);
      n_cmp++;
      if (acc_q.size() !== 2 || acc_q[0].addr !== 11'd2047 || acc_q[1].addr !== 11'd0 ||
          acc_q[0].d !== exp_q[0].d || acc_q[1].d !== exp_q[1].d) begin
         n_err++; $display("FAIL wrap: got %0d accesses addr %0d,%0d, required 2 accesses 2047,0",
                           acc_q.size(), acc_q[0].addr, acc_q[1].addr);
      end
   endtask

   task automatic test_len0();
      stim_q.delete();
      run_pass(11'd50, 12'd0, 1'b0, 1'b0, 0, 0);
      n_cmp++;
      if (acc_q.size() !== 0 || done_cyc !== 1 || done_cnt !== 1 || !busy_ok) begin
         n_err++; $display("FAIL len0: got accesses=%0d done_cyc=%0d cnt=%0d busy_ok=%0d, required 0/1/1/1",
                           acc_q.size(), done_cyc, done_cnt, busy_ok);
      end
   endtask

   task automatic test_busy_start();
      int extra = 0;
      stim_q.delete();
      for (int i = 0; i < 4; i++) stim_q.push_back(rand_word());
      ref_pass(11'd300, 4, 1, 0);
      run_pass(11'd300, 12'd4, 1'b1, 1'b0, 0, 2);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk); #1;
         if (!cen || done) extra++;
      end
      n_cmp++;
      if (acc_q.size() !== 4 || done_cnt !== 1 || extra !== 0) begin
         n_err++; $display("FAIL busy_start: got accesses=%0d done=%0d extra=%0d, required 4/1/0",
                           acc_q.size(), done_cnt, extra);
      end
      for (int i = 0; i < 4 && i < acc_q.size(); i++) begin
         n_cmp++;
         if (acc_q[i].addr !== exp_q[i].addr || acc_q[i].d !== exp_q[i].d) begin
            n_err++; $display("FAIL busy_start_w%0d: got addr=%0d d=%h, required %0d/%h",
                              i, acc_q[i].addr, acc_q[i].d, exp_q[i].addr, exp_q[i].d);
         end
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 6; it++) begin
         logic [10:0] b;
         int l;
         int m;
         b = 11'($urandom_range(600, 2047));
         l = $urandom_range(1, 5);
         for (int p = 0; p < 2; p++) begin
            bit r;
            r = 1'($urandom_range(0, 1));
            m = $urandom_range(0, 1);
            stim_q.delete();
            for (int i = 0; i < l; i++) stim_q.push_back(rand_word());
            ref_pass(b, l, (p == 0), r);
            run_pass(b, 12'(l), (p == 0), r, m, 0);
            n_cmp++;
            if (acc_q.size() !== exp_q.size() || done_cnt !== 1 || !busy_ok ||
                (acc_q.size() > 0 && done_cyc !== acc_q[acc_q.size()-1].cyc + 1)) begin
               n_err++; $display("FAIL rand%0d_%0d_shape: got accesses=%0d done=%0d busy_ok=%0d, required %0d/1/1",
                                 it, p, acc_q.size(), done_cnt, busy_ok, exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
               n_cmp++;
               if (acc_q[i].wen !== exp_q[i].wen || acc_q[i].addr !== exp_q[i].addr ||
                   (!exp_q[i].wen && acc_q[i].d !== exp_q[i].d)) begin
                  n_err++; $display("FAIL rand%0d_%0d_acc%0d: got wen=%b addr=%0d d=%h, required wen=%b addr=%0d d=%h",
                                    it, p, i, acc_q[i].wen, acc_q[i].addr, acc_q[i].d,
                                    exp_q[i].wen, exp_q[i].addr, exp_q[i].d);
               end
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      bit found = 0;
      int bad = 0;
      @(negedge clk);
      start = 1'b1; base = 11'd0; len = 12'd4; first = 1'b0; relu = 1'b0;
      in_valid = 1'b1; in_data = rand_word();
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         #1;
         if (!cen && !wen) found = 1;
         else @(negedge clk);
      end
      n_cmp++;
      if (!found) begin
         n_err++; $display("FAIL rstmid_reach: no write cycle seen, required one");
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({in_ready, cen, wen, busy, done} !== 5'b01100 || saddr !== 11'd0 || sd !== 128'd0) begin
         n_err++; $display("FAIL rstmid_async: got ready/cen/wen/busy/done=%b addr=%0d, required 01100/0",
                           {in_ready, cen, wen, busy, done}, saddr);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk); #1;
         if (!cen || done || busy) bad++;
      end
      in_valid = 1'b0;
      n_cmp++;
      if (bad !== 0) begin
         n_err++; $display("FAIL rstmid_quiet: got %0d active cycles after reset, required 0", bad);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 2048; i++) ref_mem[i] = 128'd0;
      test_reset();
      test_overwrite();
      test_accumulate();
      test_saturation_relu();
      test_stall();
      test_wrap();
      test_len0();
      test_busy_start();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
